fft_butterfly: RTL and testbench

- Pipelined radix-2 DIT butterfly for the tuner FFT, directly downstream of the Q1.15 multiply primitives.
- Computes X0 = (A + B·W)/2 and X1 = (A − B·W)/2 on packed complex Q1.15 samples.
- Fed by the FFT address/twiddle sequencer; results go to the FFT working RAM.
- Valid/ready handshake with full-pipeline stall on backpressure.

---
 rtl/fft_butterfly.sv | 142 ++++++++++++++
 tb/tb_fft_butterfly.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly.sv
// Three-stage pipelined radix-2 DIT butterfly: x0 = (a + b*tw)/2, x1 = (a - b*tw)/2 on packed complex Q1.(W-1).
// Optional macro BFLY_ROUND_EN selects round-half-up instead of truncation at the output halving.
module fft_butterfly #(
    parameter int W    = 16,
    parameter int TAGW = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*W-1:0]    a,
    input  logic [2*W-1:0]    b,
    input  logic [2*W-1:0]    tw,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    x0,
    output logic [2*W-1:0]    x1,
    output logic [TAGW-1:0]   out_tag
);

    localparam int PW  = 2*W + 1;
    localparam int BWW = W + 2;
    localparam int SW  = W + 3;

    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 <<< (W-1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

`ifdef BFLY_ROUND_EN
    localparam logic signed [SW-1:0] RND = SW'(1);
`else
    localparam logic signed [SW-1:0] RND = '0;
`endif

    logic                    s1Valid_q;
    logic [2*W-1:0]          s1A_q;
    logic [2*W-1:0]          s1B_q;
    logic [2*W-1:0]          s1Tw_q;
    logic [TAGW-1:0]         s1Tag_q;

    logic                    s2Valid_q;
    logic [2*W-1:0]          s2A_q;
    logic signed [BWW-1:0]   s2BwRe_q;
    logic signed [BWW-1:0]   s2BwIm_q;
    logic [TAGW-1:0]         s2Tag_q;

    logic                    s3Valid_q;
    logic [2*W-1:0]          x0_q;
    logic [2*W-1:0]          x1_q;
    logic [TAGW-1:0]         tag_q;

    logic                    stall;

    // One global stall: a held output freezes every stage so bubbles never collapse.
    assign stall    = s3Valid_q && !out_ready;
    assign in_ready = !stall;

    logic signed [W-1:0]     bRe, bIm, wRe, wIm;
    logic signed [PW-1:0]    prodRe, prodIm;
    logic signed [BWW-1:0]   s2BwRe_d, s2BwIm_d;

    // Full-precision complex product; W+2 bits after the shift so 0x8000*0x8000 sums cannot wrap.
    always_comb begin
        bRe      = s1B_q[2*W-1:W];
        bIm      = s1B_q[W-1:0];
        wRe      = s1Tw_q[2*W-1:W];
        wIm      = s1Tw_q[W-1:0];
        prodRe   = PW'(bRe) * PW'(wRe) - PW'(bIm) * PW'(wIm);
        prodIm   = PW'(bRe) * PW'(wIm) + PW'(bIm) * PW'(wRe);
        s2BwRe_d = BWW'(prodRe >>> (W-1));
        s2BwIm_d = BWW'(prodIm >>> (W-1));
    end

    function automatic logic [W-1:0] satHalf(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] h;
        logic [W-1:0]         r;
        h = v >>> 1;
        if (h > SAT_MAX) begin
            r = SAT_MAX[W-1:0];
        end else if (h < SAT_MIN) begin
            r = SAT_MIN[W-1:0];
        end else begin
            r = h[W-1:0];
        end
        return r;
    endfunction

    logic signed [W-1:0]     aRe, aIm;
    logic signed [SW-1:0]    sumRe, sumIm, difRe, difIm;
    logic [2*W-1:0]          x0_d, x1_d;

    always_comb begin
        aRe   = s2A_q[2*W-1:W];
        aIm   = s2A_q[W-1:0];
        sumRe = SW'(aRe) + SW'(s2BwRe_q) + RND;
        sumIm = SW'(aIm) + SW'(s2BwIm_q) + RND;
        difRe = SW'(aRe) - SW'(s2BwRe_q) + RND;
        difIm = SW'(aIm) - SW'(s2BwIm_q) + RND;
        x0_d  = {satHalf(sumRe), satHalf(sumIm)};
        x1_d  = {satHalf(difRe), satHalf(difIm)};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1Valid_q <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
            s1Tw_q    <= '0;
            s1Tag_q   <= '0;
            s2Valid_q <= 1'b0;
            s2A_q     <= '0;
            s2BwRe_q  <= '0;
            s2BwIm_q  <= '0;
            s2Tag_q   <= '0;
            s3Valid_q <= 1'b0;
            x0_q      <= '0;
            x1_q      <= '0;
            tag_q     <= '0;
        end else if (!stall) begin
            s1Valid_q <= in_valid;
            s1A_q     <= a;
            s1B_q     <= b;
            s1Tw_q    <= tw;
            s1Tag_q   <= in_tag;
            s2Valid_q <= s1Valid_q;
            s2A_q     <= s1A_q;
            s2BwRe_q  <= s2BwRe_d;
            s2BwIm_q  <= s2BwIm_d;
            s2Tag_q   <= s1Tag_q;
            s3Valid_q <= s2Valid_q;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            tag_q     <= s2Tag_q;
        end
    end

    assign out_valid = s3Valid_q;
    assign x0        = x0_q;
    assign x1        = x1_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_fft_butterfly.sv
// Scoreboard bench for fft_butterfly: directed vectors queue their expected results, a negedge monitor checks outputs.
module tb_fft_butterfly;

    localparam int W    = 16;
    localparam int TAGW = 10;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [2*W-1:0]    a;
    logic [2*W-1:0]    b;
    logic [2*W-1:0]    tw;
    logic [TAGW-1:0]   in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [2*W-1:0]    x0;
    logic [2*W-1:0]    x1;
    logic [TAGW-1:0]   out_tag;

    fft_butterfly #(.W(W), .TAGW(TAGW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .tw        (tw),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x0        (x0),
        .x1        (x1),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*W-1:0]  x0;
        logic [2*W-1:0]  x1;
        logic [TAGW-1:0] tag;
    } exp_t;

    exp_t expQ[$];
    int   errorCount = 0;
    int   checkCount = 0;

    task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkCount++;
        if (x0 !== e.x0 || x1 !== e.x1 || out_tag !== e.tag) begin
            errorCount++;
            $display("[TB] FAIL result tag=0x%0h: got x0=0x%h x1=0x%h tag=0x%h, expected x0=0x%h x1=0x%h tag=0x%h",
                     e.tag, x0, x1, out_tag, e.x0, e.x1, e.tag);
        end
    endtask

    // Monitor: every presented output is compared to the queue head; it is only popped when accepted.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (expQ.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected_output: got tag=0x%h x0=0x%h x1=0x%h, expected no output", out_tag, x0, x1);
            end else begin
                checkOutput(expQ[0]);
                if (out_ready) void'(expQ.pop_front());
            end
        end
    end

    // Drives one cycle starting at posedge+1; reports in_ready/out_valid as seen at the negedge.
    task automatic applyStimulus(input logic v, input logic [2*W-1:0] aIn, input logic [2*W-1:0] bIn,
                                 input logic [2*W-1:0] twIn, input logic [TAGW-1:0] tag,
                                 input logic [2*W-1:0] e0, input logic [2*W-1:0] e1, input logic rdy,
                                 output logic acc, output logic rdySeen, output logic vldSeen);
        exp_t e;
        in_valid  = v;
        a         = aIn;
        b         = bIn;
        tw        = twIn;
        in_tag    = tag;
        out_ready = rdy;
        @(negedge clk);
        rdySeen = in_ready;
        vldSeen = out_valid;
        acc     = v && in_ready;
        @(posedge clk);
        if (acc) begin
            e.x0 = e0;
            e.x1 = e1;
            e.tag = tag;
            expQ.push_back(e);
        end
        #1;
    endtask

    task automatic idleCycle(output logic vldSeen);
        logic acc, rdySeen;
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, acc, rdySeen, vldSeen);
    endtask

    task automatic drain(input string name);
        logic vld;
        int   n = 0;
        while (expQ.size() != 0 && n < 20) begin
            idleCycle(vld);
            n++;
        end
        idleCycle(vld);
        checkValue(name, 64'(expQ.size()), 64'd0);
    endtask

    logic [2*W-1:0] dirA[3]  = '{32'h4000_0000, 32'h0000_0000, 32'h0000_7FFF};
    logic [2*W-1:0] dirB[3]  = '{32'h4000_0000, 32'h4000_2000, 32'h8000_8000};
    logic [2*W-1:0] dirTw[3] = '{32'h7FFF_0000, 32'h0000_8000, 32'h8000_8000};
`ifdef BFLY_ROUND_EN
    logic [2*W-1:0] dirE0[3] = '{32'h4000_0000, 32'h1000_E000, 32'h0000_7FFF};
    logic [2*W-1:0] dirE1[3] = '{32'h0001_0000, 32'hF000_2000, 32'h0000_C000};
`else
    logic [2*W-1:0] dirE0[3] = '{32'h3FFF_0000, 32'h1000_E000, 32'h0000_7FFF};
    logic [2*W-1:0] dirE1[3] = '{32'h0000_0000, 32'hF000_2000, 32'h0000_BFFF};
`endif

    // With tw = 0 the product vanishes whatever b is, so x0 = x1 = a/2 (even parts, rounding-invariant).
    logic [2*W-1:0] bpA[6] = '{32'h0100_0000, 32'h0200_FF00, 32'h0300_0002,
                               32'h0400_FFFE, 32'h7FFE_8000, 32'h8000_7FFE};
    logic [2*W-1:0] bpE[6] = '{32'h0080_0000, 32'h0100_FF80, 32'h0180_0001,
                               32'h0200_FFFF, 32'h3FFF_C000, 32'hC000_3FFF};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc, rdySeen, vldSeen;
        int   idx;
        int   cyc;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        tw        = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #12;
        checkValue("reset_out_valid", 64'(out_valid), 64'd0);
        checkValue("reset_x0",        64'(x0),        64'd0);
        checkValue("reset_x1",        64'(x1),        64'd0);
        checkValue("reset_out_tag",   64'(out_tag),   64'd0);
        checkValue("reset_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, dirA[i], dirB[i], dirTw[i], TAGW'(i + 1), dirE0[i], dirE1[i], 1'b1,
                          acc, rdySeen, vldSeen);
        end
        drain("directed_drain");

        $display("[TB] backpressure");
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 40) begin
            applyStimulus(1'b1, bpA[idx], 32'h1234_5678, 32'h0000_0000, TAGW'(idx + 1), bpE[idx], bpE[idx],
                          !(cyc >= 4 && cyc <= 8), acc, rdySeen, vldSeen);
            checkValue($sformatf("bp_in_ready_c%0d", cyc), 64'(rdySeen), 64'(!(cyc >= 4 && cyc <= 8)));
            checkValue($sformatf("bp_out_valid_c%0d", cyc), 64'(vldSeen), 64'(cyc >= 3));
            if (acc) idx++;
            cyc++;
        end
        checkValue("bp_all_issued", 64'(idx), 64'd6);
        drain("bp_drain");

        $display("[TB] bubbles");
        for (int i = 0; i < 11; i++) begin
            applyStimulus((i < 8) && (i % 2 == 0), 32'h0010_0020, 32'h0000_0000, 32'h0000_0000,
                          TAGW'(10'h020 + i), 32'h0008_0010, 32'h0008_0010, 1'b1, acc, rdySeen, vldSeen);
            checkValue($sformatf("bubble_out_valid_c%0d", i), 64'(vldSeen),
                       64'((i >= 3) && ((i - 3) % 2 == 0)));
        end
        drain("bubble_drain");

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h1000_0000, 32'h0000_0000, 32'h0000_0000, TAGW'(10'h030 + i),
                          32'h0800_0000, 32'h0800_0000, 1'b1, acc, rdySeen, vldSeen);
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        expQ.delete();
        #1;
        checkValue("midreset_out_valid", 64'(out_valid), 64'd0);
        checkValue("midreset_x0",        64'(x0),        64'd0);
        checkValue("midreset_x1",        64'(x1),        64'd0);
        checkValue("midreset_out_tag",   64'(out_tag),   64'd0);
        checkValue("midreset_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            idleCycle(vldSeen);
            checkValue($sformatf("post_reset_out_valid_c%0d", i), 64'(vldSeen), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
